absorb: RTL and testbench

Absorb phase of the sponge construction; the write-side counterpart of squeez.
- Takes an initial rate/capacity state and a message of msg_len bits, streamed RWIDTH bits per handshake.
- XORs each (padded) block into the rate and drives one permutation run per block through the G go/done interface.
- Hands the final rate/capacity to squeez on absorbDone.

---
 rtl/sponge_pkg.sv | 19 +
 rtl/absorb_if.sv | 36 +++
 rtl/absorb_pad.sv | 19 +
 rtl/absorb.sv | 112 +++++++++++
 tb/tb_absorb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sponge_pkg.sv
// Shared sponge definitions: phase state encoding and default widths,
// common to the absorb and squeeze phases.
package sponge_pkg;

    localparam int CWIDTH_DEF      = 320;
    localparam int RWIDTH_DEF      = 32;
    localparam int REMAINWIDTH_DEF = 20;
    localparam int ROUND_COUNT_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAITDATA,
        XOR,
        PERM,
        DONE
    } state_type;

endpackage

// File: rtl/absorb_if.sv
// Absorb-phase bus: message stream, initial state, G permutation port
// and the final state handed on to the squeeze phase.
interface absorb_if #(
    parameter int CWIDTH      = sponge_pkg::CWIDTH_DEF,
    parameter int RWIDTH      = sponge_pkg::RWIDTH_DEF,
    parameter int REMAINWIDTH = sponge_pkg::REMAINWIDTH_DEF
);
    logic                   en;
    logic [REMAINWIDTH-1:0] msg_len;
    logic [RWIDTH-1:0]      r_in;
    logic [CWIDTH-1:0]      c_in;
    logic [RWIDTH-1:0]      din;
    logic                   din_valid;
    logic                   din_ready;
    logic                   Ggo;
    logic [RWIDTH-1:0]      G_rin;
    logic [CWIDTH-1:0]      G_cin;
    logic [RWIDTH-1:0]      G_rout;
    logic [CWIDTH-1:0]      G_cout;
    logic                   Gdone;
    logic [RWIDTH-1:0]      r_out;
    logic [CWIDTH-1:0]      c_out;
    logic                   absorbDone;

    // slave: the absorb block itself
    modport slave (
        input  en, msg_len, r_in, c_in, din, din_valid, G_rout, G_cout, Gdone,
        output din_ready, Ggo, G_rin, G_cin, r_out, c_out, absorbDone
    );

    // master: the surrounding system (message source, G instance, squeeze)
    modport master (
        output en, msg_len, r_in, c_in, din, din_valid, G_rout, G_cout, Gdone,
        input  din_ready, Ggo, G_rin, G_cin, r_out, c_out, absorbDone
    );
endinterface

// File: rtl/absorb_pad.sv
// pad10* block former: keeps the low i_remain bits of i_din and sets bit
// i_remain; a word with i_remain >= RWIDTH passes through unchanged.
module absorb_pad #(
    parameter int RWIDTH      = sponge_pkg::RWIDTH_DEF,
    parameter int REMAINWIDTH = sponge_pkg::REMAINWIDTH_DEF
) (
    input  logic [RWIDTH-1:0]      i_din,
    input  logic [REMAINWIDTH-1:0] i_remain,
    output logic [RWIDTH-1:0]      o_block
);
    genvar gi;
    generate
        for (gi = 0; gi < RWIDTH; gi++) begin : g_bit
            localparam logic [REMAINWIDTH-1:0] L_POS = REMAINWIDTH'(gi);
            // below the cut: message bit; at the cut: the pad 1; above: 0
            assign o_block[gi] = (L_POS < i_remain) ? i_din[gi] : (L_POS == i_remain);
        end
    endgenerate
endmodule

// File: rtl/absorb.sv
// Sponge absorb phase: XORs each padded message block into the rate and
// runs one G permutation per block, then presents the final state.
module absorb
    import sponge_pkg::*;
#(
    parameter int CWIDTH      = CWIDTH_DEF,
    parameter int RWIDTH      = RWIDTH_DEF,
    parameter int REMAINWIDTH = REMAINWIDTH_DEF
) (
    input  logic     clk,
    input  logic     reset,
    absorb_if.slave  bus
);
    localparam logic [REMAINWIDTH-1:0] L_RW = REMAINWIDTH'(RWIDTH);

    state_type              r_state, w_state_next;
    logic [RWIDTH-1:0]      r_rreg, w_rreg_next;
    logic [CWIDTH-1:0]      r_creg, w_creg_next;
    logic [REMAINWIDTH-1:0] r_remain, w_remain_next;
    logic [RWIDTH-1:0]      r_blk, w_blk_next;
    logic                   r_final, w_final_next;
    logic [RWIDTH-1:0]      w_pad;

    absorb_pad #(
        .RWIDTH      (RWIDTH),
        .REMAINWIDTH (REMAINWIDTH)
    ) u_pad (
        .i_din    (bus.din),
        .i_remain (r_remain),
        .o_block  (w_pad)
    );

    assign bus.G_rin      = r_rreg;
    assign bus.G_cin      = r_creg;
    assign bus.r_out      = r_rreg;
    assign bus.c_out      = r_creg;
    assign bus.Ggo        = (r_state == PERM);
    assign bus.absorbDone = (r_state == DONE);
    assign bus.din_ready  = (r_state == WAITDATA) && (r_remain != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rreg   <= '0;
            r_creg   <= '0;
            r_remain <= '0;
            r_blk    <= '0;
            r_final  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rreg   <= w_rreg_next;
            r_creg   <= w_creg_next;
            r_remain <= w_remain_next;
            r_blk    <= w_blk_next;
            r_final  <= w_final_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rreg_next   = r_rreg;
        w_creg_next   = r_creg;
        w_remain_next = r_remain;
        w_blk_next    = r_blk;
        w_final_next  = r_final;

        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_rreg_next   = bus.r_in;
                    w_creg_next   = bus.c_in;
                    w_remain_next = bus.msg_len;
                    w_state_next  = LOAD;
                end
            end
            LOAD: w_state_next = WAITDATA;
            WAITDATA: begin
                // an exhausted message still owes one pad-only block
                if (r_remain == '0) begin
                    w_blk_next   = w_pad;
                    w_final_next = 1'b1;
                    w_state_next = XOR;
                end else if (bus.din_valid) begin
                    w_blk_next = w_pad;
                    if (r_remain >= L_RW) begin
                        w_remain_next = r_remain - L_RW;
                        w_final_next  = 1'b0;
                    end else begin
                        w_remain_next = '0;
                        w_final_next  = 1'b1;
                    end
                    w_state_next = XOR;
                end
            end
            XOR: begin
                w_rreg_next  = r_rreg ^ r_blk;
                w_state_next = PERM;
            end
            PERM: begin
                if (bus.Gdone) begin
                    w_rreg_next  = bus.G_rout;
                    w_creg_next  = bus.G_cout;
                    w_state_next = r_final ? DONE : WAITDATA;
                end
            end
            DONE: begin
                if (!bus.en) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_absorb.sv
// Randomised and directed bench for absorb with a 3-cycle G stub and a
// block-by-block reference model of the sponge absorb.
module tb_absorb;
    import sponge_pkg::*;

    localparam int CW = CWIDTH_DEF;
    localparam int RW = RWIDTH_DEF;
    localparam int LW = REMAINWIDTH_DEF;

    typedef logic [RW-1:0] word_q_t[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    absorb_if #(.CWIDTH(CW), .RWIDTH(RW), .REMAINWIDTH(LW)) bus ();

    absorb #(.CWIDTH(CW), .RWIDTH(RW), .REMAINWIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // G stub: fixed transform, Gdone three cycles after Ggo is first seen
    int unsigned g_cnt;
    assign bus.G_rout = bus.G_rin ^ 32'hA5A5A5A5;
    assign bus.G_cout = bus.G_cin + 1'b1;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            g_cnt     <= 0;
            bus.Gdone <= 1'b0;
        end else if (bus.Gdone) begin
            g_cnt     <= 0;
            bus.Gdone <= 1'b0;
        end else if (bus.Ggo) begin
            if (g_cnt == 2) bus.Gdone <= 1'b1;
            else            g_cnt     <= g_cnt + 1;
        end
    end

    // activity monitor: handshakes, Ggo bursts, permutation outputs
    int        hs_total = 0;
    int        go_total = 0;
    logic      go_prev  = 1'b0;
    logic [RW-1:0] perm_out[$];
    always @(posedge clk) begin
        if (bus.din_valid && bus.din_ready) hs_total <= hs_total + 1;
        if (bus.Ggo && !go_prev)            go_total <= go_total + 1;
        if (bus.Gdone && bus.Ggo)           perm_out.push_back(bus.G_rout);
        go_prev <= bus.Ggo;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: split the message into RW-bit blocks; the block where fewer
    // than RW bits remain (possibly zero) is truncated and gets the pad 1.
    function automatic void model(input logic [RW-1:0] r0, input logic [CW-1:0] c0,
                                  input int len, input word_q_t w,
                                  output logic [RW-1:0] r, output logic [CW-1:0] c,
                                  output int perms);
        longint unsigned blk, word;
        int rem;
        r = r0;
        c = c0;
        perms = len / RW + 1;
        for (int i = 0; i < perms; i++) begin
            rem  = len - i * RW;
            word = (i < w.size()) ? longint'(w[i]) : 0;
            if (rem >= RW) blk = word;
            else           blk = (word & ((64'd1 << rem) - 1)) | (64'd1 << rem);
            r = (r ^ blk[RW-1:0]) ^ 32'hA5A5A5A5;
            c = c + 1;
        end
    endfunction

    task automatic run_msg(input string tag, input logic [RW-1:0] r0, input logic [CW-1:0] c0,
                           input int len, input word_q_t words, input bit stall, input bit noise,
                           output logic [RW-1:0] r_obs, output logic [CW-1:0] c_obs,
                           output logic [RW-1:0] first_perm);
        int hs0, go0, pq0, idx, exp_p;
        bit done, seen_ready, hs, do_stall, ok_rdy, ok_go, ok_r, ok_c;
        logic [RW-1:0] exp_r, snap_r;
        logic [CW-1:0] exp_c, snap_c;
        hs0 = hs_total; go0 = go_total; pq0 = perm_out.size();
        idx = 0; done = 0; seen_ready = 0; do_stall = stall;
        ok_rdy = 1; ok_go = 1; ok_r = 1; ok_c = 1;
        @(negedge clk);
        bus.r_in = r0; bus.c_in = c0; bus.msg_len = LW'(len);
        bus.en = 1'b1; bus.din_valid = 1'b0;
        @(negedge clk);
        bus.en = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (bus.absorbDone) begin
                done = 1;
            end else begin
                if (bus.din_ready) seen_ready = 1;
                if (do_stall && bus.din_ready) begin
                    do_stall = 0;
                    snap_r = bus.G_rin; snap_c = bus.G_cin;
                    bus.din_valid = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        if (!bus.din_ready)       ok_rdy = 0;
                        if (bus.Ggo)              ok_go  = 0;
                        if (bus.G_rin !== snap_r) ok_r   = 0;
                        if (bus.G_cin !== snap_c) ok_c   = 0;
                    end
                    check({tag, " stall din_ready"}, ok_rdy, 1);
                    check({tag, " stall Ggo low"},   ok_go,  1);
                    check({tag, " stall rReg"},      ok_r,   1);
                    check({tag, " stall cReg"},      ok_c,   1);
                end
                bus.din = (idx < words.size()) ? words[idx] : RW'($urandom);
                bus.din_valid = (idx < words.size()) && (noise ? ($urandom_range(0, 2) != 0) : 1'b1);
                hs = bus.din_valid && bus.din_ready;
                @(negedge clk);
                if (hs) idx++;
            end
        end
        bus.din_valid = 1'b0;
        r_obs = bus.r_out;
        c_obs = bus.c_out;
        first_perm = (perm_out.size() > pq0) ? perm_out[pq0] : 'x;
        model(r0, c0, len, words, exp_r, exp_c, exp_p);
        check({tag, " absorbDone"}, done, 1);
        check({tag, " r_out"}, r_obs, exp_r);
        check({tag, " c_out"}, c_obs, exp_c);
        check({tag, " permutations"}, go_total - go0, exp_p);
        check({tag, " handshakes"}, hs_total - hs0, (len + RW - 1) / RW);
        check({tag, " din_ready seen"}, seen_ready, len > 0);
        $display("txn %s len=%0d r_out=%h c_out[31:0]=%h perms=%0d hs=%0d",
                 tag, len, r_obs, c_obs[31:0], go_total - go0, hs_total - hs0);
    endtask

    function automatic word_q_t rand_words(input int len);
        word_q_t q;
        for (int i = 0; i < (len + RW - 1) / RW; i++) q.push_back(RW'($urandom));
        return q;
    endfunction

    initial begin
        word_q_t w;
        logic [RW-1:0] r_o, fp, r0;
        logic [CW-1:0] c_o, c0;
        int len;
        bit found;

        bus.en = 1'b0; bus.msg_len = '0; bus.r_in = '0; bus.c_in = '0;
        bus.din = '0; bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset Ggo", bus.Ggo, 0);
        check("reset absorbDone", bus.absorbDone, 0);
        check("reset din_ready", bus.din_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle r_out", bus.r_out, 0);
        check("idle c_out", bus.c_out, 0);
        check("idle G_rin", bus.G_rin, 0);

        w = {};
        run_msg("s1_len0", '0, '0, 0, w, 0, 0, r_o, c_o, fp);
        check("s1 r_out const", r_o, 32'hA5A5A5A4);
        check("s1 c_out const", c_o, 1);

        w = {32'hDEADBEEF};
        run_msg("s2_len32", '0, '0, 32, w, 0, 0, r_o, c_o, fp);
        check("s2 block1 rReg", fp, 32'h7B081B4A);
        check("s2 r_out const", r_o, 32'hDEADBEEE);
        check("s2 c_out const", c_o, 2);

        w = {32'hFFFFFF3C};
        run_msg("s3_len8", '0, '0, 8, w, 0, 0, r_o, c_o, fp);
        check("s3 r_out const", r_o, 32'hA5A5A499);
        check("s3 c_out const", c_o, 1);

        w = rand_words(70);
        run_msg("s4_len70", '0, '0, 70, w, 0, 1, r_o, c_o, fp);
        check("s4 c_out const", c_o, 3);

        w = rand_words(32);
        run_msg("s5_stall", 32'h12345678, '0, 32, w, 1, 0, r_o, c_o, fp);

        // asynchronous reset while a permutation is outstanding
        @(negedge clk);
        bus.r_in = '0; bus.c_in = '0; bus.msg_len = LW'(8); bus.en = 1'b1;
        bus.din = 32'hFFFFFF3C; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (bus.Ggo) found = 1;
        end
        check("s6 reached PERM", found, 1);
        #2 reset = 1'b1;
        #1;
        check("s6 async Ggo", bus.Ggo, 0);
        check("s6 async absorbDone", bus.absorbDone, 0);
        check("s6 async rReg", bus.G_rin, 0);
        check("s6 async cReg", bus.G_cin, 0);
        bus.din_valid = 1'b0;
        #1 reset = 1'b0;
        $display("txn s6_reset_mid_perm found=%0d", found);
        w = {32'hFFFFFF3C};
        run_msg("s6_rerun", '0, '0, 8, w, 0, 0, r_o, c_o, fp);
        check("s6 r_out const", r_o, 32'hA5A5A499);
        check("s6 c_out const", c_o, 1);

        for (int t = 0; t < 8; t++) begin
            len = (t == 0) ? 64 : int'($urandom_range(0, 100));
            r0 = RW'($urandom);
            c0 = '0;
            for (int k = 0; k < CW / 32; k++) c0 = {c0[CW-33:0], 32'($urandom)};
            w = rand_words(len);
            run_msg($sformatf("rand%0d", t), r0, c0, len, w, 0, 1, r_o, c_o, fp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
